bt656_crop_writer: RTL

Parametrised BT.656 front end on the camera clock domain. It parses TRS codes, tracks field, line and word position, and crops a configurable window from both fields. It writes either luma-only or full 4:2:2 words, with packet sideband, into the write side of the dual-clock video FIFO. It generalises the fixed 720x576 Y-only capture path: data width, line length, crop window and Y/YC mode are parameters, and it adds TRS protection checking, lock-loss handling and frame-abort on overflow.

---
 rtl/bt656_pkg.sv | 44 ++++
 rtl/bt656_trs_detect.sv | 47 ++++
 rtl/bt656_crop_writer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/bt656_pkg.sv
// Shared types and TRS helpers for the BT.656 capture front end.
package bt656_pkg;

   typedef enum logic [1:0] {
      HUNT,
      WAIT_FRAME,
      BLANK,
      ACTIVE
   } bt_state_t;

   localparam int MAX_LINES = 625;
   localparam int LINE_W    = $clog2(MAX_LINES);

   function automatic int trs_ones(input int dw);
      return (1 << dw) - 1;
   endfunction

   function automatic int f_idx(input int dw);
      return dw - 2;
   endfunction

   function automatic int v_idx(input int dw);
      return dw - 3;
   endfunction

   function automatic int h_idx(input int dw);
      return dw - 4;
   endfunction

   // 10-bit words carry the protection nibble two bits up
   function automatic int p_lsb(input int dw);
      return (dw == 10) ? 2 : 0;
   endfunction

   function automatic logic prot_ok(
      input logic       f,
      input logic       v,
      input logic       h,
      input logic [3:0] p
   );
      return p == {v ^ h, f ^ h, f ^ v, f ^ v ^ h};
   endfunction

endpackage

// File: rtl/bt656_trs_detect.sv
// Three-word preamble history and XY validation; outputs align with XY.
module bt656_trs_detect
   import bt656_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  bt_clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] bt_data,
   input  logic                  bt_datavalid,
   output logic                  trs_valid,
   output logic                  f,
   output logic                  v,
   output logic                  h
);

   localparam logic [DATA_WIDTH-1:0] ONES = DATA_WIDTH'(trs_ones(DATA_WIDTH));
   localparam int FI = f_idx(DATA_WIDTH);
   localparam int VI = v_idx(DATA_WIDTH);
   localparam int HI = h_idx(DATA_WIDTH);
   localparam int PL = p_lsb(DATA_WIDTH);

   logic [DATA_WIDTH-1:0] w1, w2, w3;
   logic [3:0]            p;

   always_ff @(posedge bt_clock or posedge reset) begin
      if (reset) begin
         w1 <= '0;
         w2 <= '0;
         w3 <= '0;
      end else if (bt_datavalid) begin
         w1 <= bt_data;
         w2 <= w1;
         w3 <= w2;
      end
   end

   assign f = bt_data[FI];
   assign v = bt_data[VI];
   assign h = bt_data[HI];
   assign p = bt_data[PL +: 4];

   assign trs_valid = bt_datavalid && w3 == ONES && w2 == '0 &&
                      w1 == '0 && bt_data[DATA_WIDTH-1] &&
                      prot_ok(f, v, h, p);

endmodule

// File: rtl/bt656_crop_writer.sv
// BT.656 parser and crop window writer feeding the video FIFO write side.
module bt656_crop_writer
   import bt656_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int LINE_PIXELS = 720,
   parameter int CROP_X0     = 40,
   parameter int CROP_W      = 640,
   parameter int CROP_Y0     = 24,
   parameter int CROP_H      = 240,
   parameter int MODE_YC     = 0
) (
   input  logic                  bt_clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] bt_data,
   input  logic                  bt_datavalid,
   input  logic                  bt_locked,
   output logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_sop,
   output logic                  fifo_eop,
   output logic                  fifo_wrreq,
   input  logic                  fifo_full,
   output logic                  locked,
   output logic                  bt_overflow,
   input  logic                  overflow_clr,
   output logic                  frame_dropped
);

   localparam int WORDS = 2 * LINE_PIXELS;
   localparam int WC_W  = $clog2(WORDS);
   localparam logic [WC_W-1:0] WC_LAST = WC_W'(WORDS - 1);
   localparam logic [WC_W-1:0] WC_LO   = WC_W'(2 * CROP_X0);
   localparam logic [WC_W-1:0] WC_HI   = WC_W'(2 * (CROP_X0 + CROP_W) - 1);
   localparam logic [LINE_W-1:0] Y_LO  = LINE_W'(CROP_Y0);
   localparam logic [LINE_W-1:0] Y_HI  = LINE_W'(CROP_Y0 + CROP_H - 1);

   logic              trs_valid, trs_f, trs_v, trs_h;
   bt_state_t         state_q, state_d;
   logic [WC_W-1:0]   wc;
   logic [LINE_W-1:0] line_cnt, act_line;
   logic              cur_f, prev_f, writing, sop_pend;
   logic              lock_go, sav_go, in_win, elig, last_word;

   bt656_trs_detect #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_trs (
      .bt_clock     (bt_clock),
      .reset        (reset),
      .bt_data      (bt_data),
      .bt_datavalid (bt_datavalid),
      .trs_valid    (trs_valid),
      .f            (trs_f),
      .v            (trs_v),
      .h            (trs_h)
   );

   always_ff @(posedge bt_clock or posedge reset) begin
      if (reset) state_q <= HUNT;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (!bt_locked) begin
         state_d = HUNT;
      end else if (bt_datavalid) begin
         unique case (state_q)
            HUNT:
               if (trs_valid) state_d = WAIT_FRAME;
            WAIT_FRAME:
               if (trs_valid && prev_f && !trs_f && trs_v && !trs_h)
                  state_d = BLANK;
            BLANK:
               if (trs_valid && !trs_v && !trs_h) state_d = ACTIVE;
            ACTIVE:
               if (trs_valid ? trs_h : (wc == WC_LAST)) state_d = BLANK;
            default:
               state_d = HUNT;
         endcase
      end
   end

   assign lock_go   = state_q == WAIT_FRAME && state_d == BLANK;
   assign sav_go    = state_q == BLANK && state_d == ACTIVE;
   assign in_win    = act_line >= Y_LO && act_line <= Y_HI &&
                      wc >= WC_LO && wc <= WC_HI;
   assign elig      = state_q == ACTIVE && bt_locked && bt_datavalid &&
                      !trs_valid && in_win && (MODE_YC != 0 || wc[0]);
   assign last_word = cur_f && act_line == Y_HI && wc == WC_HI;

   always_ff @(posedge bt_clock or posedge reset) begin
      if (reset) begin
         fifo_data     <= '0;
         fifo_sop      <= 1'b0;
         fifo_eop      <= 1'b0;
         fifo_wrreq    <= 1'b0;
         locked        <= 1'b0;
         bt_overflow   <= 1'b0;
         frame_dropped <= 1'b0;
         wc            <= '0;
         line_cnt      <= '0;
         act_line      <= '0;
         cur_f         <= 1'b0;
         prev_f        <= 1'b0;
         writing       <= 1'b0;
         sop_pend      <= 1'b0;
      end else begin
         fifo_wrreq    <= 1'b0;
         fifo_sop      <= 1'b0;
         fifo_eop      <= 1'b0;
         frame_dropped <= 1'b0;
         if (overflow_clr) bt_overflow <= 1'b0;
         if (lock_go) locked <= 1'b1;
         if (trs_valid) begin
            prev_f <= trs_f;
            if (trs_v)      line_cnt <= '0;
            else if (trs_h) line_cnt <= line_cnt + 1'b1;
         end
         if (sav_go) begin
            wc       <= '0;
            act_line <= line_cnt;
            cur_f    <= trs_f;
            if (!trs_f && line_cnt == Y_LO) begin
               writing  <= 1'b1;
               sop_pend <= 1'b1;
            end
         end else if (state_q == ACTIVE && bt_datavalid && !trs_valid) begin
            wc <= wc + 1'b1;
         end
         // a drop poisons the rest of the frame until the next field 0 start
         if (elig && writing) begin
            if (fifo_full) begin
               bt_overflow   <= 1'b1;
               frame_dropped <= 1'b1;
               writing       <= 1'b0;
               sop_pend      <= 1'b0;
            end else begin
               fifo_wrreq <= 1'b1;
               fifo_data  <= bt_data;
               fifo_sop   <= sop_pend;
               fifo_eop   <= last_word;
               sop_pend   <= 1'b0;
               if (last_word) writing <= 1'b0;
            end
         end
         if (!bt_locked) begin
            locked   <= 1'b0;
            writing  <= 1'b0;
            sop_pend <= 1'b0;
            if (writing) frame_dropped <= 1'b1;
         end
      end
   end

endmodule
